button_event: RTL and testbench
===============================

Name: button_event

Overview:
- Sits directly downstream of the button debouncer; consumes its clean, clk-synchronous level.
- Turns that level into single-cycle press, release and long-press events.
- Turns press and repeat events into a held step request, with a handshake, for the CPU single-step/run control.
- One instance per front-panel button.

Parameters:
- CW, 16, width of the hold-time counter in bits.
- LONG_TICKS, 25000, clk cycles held in DOWN before long_press fires (0.5 s at 50 kHz); must be >= 2 and < 2^CW.
- REPEAT_TICKS, 5000, clk cycles between auto-repeat events in LONG (100 ms at 50 kHz); must be >= 2 and < 2^CW.

Ports:
- clk  in  1  system clock.
- n_reset  in  1  asynchronous active-low reset.
- db_in  in  1  debounced button level, synchronous to clk; 1 = pressed.
- held  out  1  registered copy of db_in.
- press  out  1  one-cycle pulse on press.
- release  out  1  one-cycle pulse on release.
- long_press  out  1  one-cycle pulse when hold reaches LONG_TICKS.
- repeat_pulse  out  1  one-cycle auto-repeat pulse; constant 0 when the optional feature is compiled out.
- step_req  out  1  pending step request; held high until acknowledged.
- step_ack  in  1  consumer accepts the pending request.

Behaviour:
- Reset is asynchronous, active-low; one clock only (already decided).
- Reset values:
  - FSM = IDLE, cnt = 0.
  - held, press, release, long_press, repeat_pulse, step_req all 0.
- All outputs are registered. Event latency is 1 clk after db_in is sampled.
- FSM states: IDLE, DOWN, LONG. cnt is CW bits.
- IDLE:
  - db_in=1 -> press=1 next cycle, go to DOWN, cnt=0.
  - A db_in high already at reset release produces a press on the first active cycle.
- DOWN:
  - db_in=0 -> release=1, go to IDLE, cnt=0.
  - Else if cnt==LONG_TICKS-1 -> long_press=1, go to LONG, cnt=0.
  - Else cnt+1.
  - So long_press fires LONG_TICKS+1 cycles after the press pulse.
- LONG:
  - db_in=0 -> release=1, go to IDLE.
  - Else cnt behaves per the optional feature.
- Pulse exclusivity: at most one of press, release, long_press, repeat_pulse is high in any cycle.
- Release has priority over a long or repeat event in the same cycle (db_in=0 while cnt is at threshold -> release only).
- step_req handshake:
  - Set on the cycle press or repeat_pulse is asserted.
  - Cleared the cycle after step_ack=1 is sampled while step_req=1.
  - Set and ack in the same cycle -> step_req stays 1; the new event wins and events are not lost.
  - step_ack while step_req=0 is ignored.
  - Multiple events while pending collapse into one request; no counting.
- Counter never wraps: thresholds are < 2^CW, and cnt resets on every state change.
- Reset asserted mid-hold: everything returns to reset values immediately; no release pulse is emitted.

Optional Feature:
- Macro BUTTON_REPEAT_EN.
- Defined:
  - In LONG, cnt counts.
  - At cnt==REPEAT_TICKS-1 -> repeat_pulse=1, cnt=0, and step_req is set.
  - First repeat fires REPEAT_TICKS+1 cycles after long_press; subsequent repeats are every REPEAT_TICKS cycles.
- Undefined:
  - repeat_pulse tied to 0.
  - cnt holds 0 in LONG.
  - LONG waits only for release.

Decomposition:
- Shared package: FSM state encoding constants (IDLE=2'd0, DOWN=2'd1, LONG=2'd2) and the default tick constants for 50 kHz, shared with the debouncer N choice.
- Sub-module: none required. Optionally step_handshake, a set/ack request flag reusable by other panel inputs.

Test Plan:
- Reset, then db_in=1 for 10 cycles then 0 (LONG_TICKS=8, REPEAT_TICKS=4, repeat on) -> press at cycle 1, long_press at cycle 10, release at cycle 11 after the fall; no repeat.
- db_in=1 for 30 cycles with LONG_TICKS=8, REPEAT_TICKS=4, macro on -> long_press at cycle 10, repeat_pulse at cycles 15, 19, 23, 27; step_req set at 1 and 15 (never acked). Same stimulus with macro off -> zero repeats.
- db_in falls exactly when cnt==LONG_TICKS-1 -> release only, no long_press, state IDLE.
- Press pulse with step_ack asserted in the same cycle as a repeat_pulse -> step_req remains 1. Ack on the next cycle -> step_req=0 the following cycle.
- n_reset pulled low while in LONG with step_req=1 -> all outputs 0 asynchronously, no release pulse. Release reset with db_in=1 -> press on first active cycle.
- step_ack held at 1 with no events for 20 cycles -> step_req stays 0; no spurious pulses.

Source files
------------

// File: rtl/button_event_pkg.sv
// ---------------------------------------------------------------------------
// button_event_pkg
//
// Purpose:
//   Shared definitions for the front-panel button event block: the FSM state
//   encoding, the default tick thresholds for the 50 kHz panel clock, and the
//   packed event bundle that the top level registers as one word.
//
//   The tick constants are derived from one clock-rate constant so that the
//   debouncer and this block agree on what "a millisecond" is. The debouncer
//   takes DEBOUNCE_TICKS as its N.
//
// Contents:
//   state_e         IDLE / DOWN / LONG encoding
//   btn_events_t    press / release / long-press / repeat pulse bundle
//   msToTicks()     converts milliseconds to panel clock cycles
//   DEFAULT_*       default parameter values for button_event
// ---------------------------------------------------------------------------
package button_event_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    LONG = 2'd2
  } state_e;

  // One bit per single-cycle event. "release" is a keyword, so that field
  // is called rel.
  typedef struct packed {
    logic press;
    logic rel;
    logic longPress;
    logic repeatPulse;
  } btn_events_t;

  localparam int CLK_HZ = 50_000;

  // Cycles of the panel clock in a whole number of milliseconds.
  function automatic int msToTicks(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int DEFAULT_CW           = 16;
  localparam int DEFAULT_LONG_TICKS   = msToTicks(500);
  localparam int DEFAULT_REPEAT_TICKS = msToTicks(100);
  localparam int DEBOUNCE_TICKS       = msToTicks(5);

endpackage

// File: rtl/button_event_step_handshake.sv
// ---------------------------------------------------------------------------
// button_event_step_handshake
//
// Purpose:
//   A single pending-request flag with a set/acknowledge handshake. Any
//   number of set pulses while the flag is already up collapse into one
//   request. An acknowledge only matters while the flag is up, and a set
//   arriving on the same clock as the acknowledge keeps the flag up so that
//   the newer event is not lost. Reusable by any panel input that needs to
//   hand a request to the CPU run/step control.
//
// Ports:
//   clk_i      system clock
//   n_reset_i  asynchronous active-low reset
//   set_i      raise (or keep) the request on the next clock
//   ack_i      consumer accepts the pending request
//   req_o      pending request, registered
// ---------------------------------------------------------------------------
module button_event_step_handshake
  import button_event_pkg::*;
(
  input  logic clk_i,
  input  logic n_reset_i,
  input  logic set_i,
  input  logic ack_i,
  output logic req_o
);

  logic req_q;
  logic req_d;

  // Next value of the request flag: a new set always wins, otherwise the
  // flag stays up until an acknowledge is seen while it is up. An
  // acknowledge while the flag is down falls through to "stay down".
  always_comb begin
    req_d = set_i | (req_q & ~ack_i);
  end

  // The flag itself. Reset drops any pending request immediately.
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      req_q <= 1'b0;
    end else begin
      req_q <= req_d;
    end
  end

  assign req_o = req_q;

endmodule

// File: rtl/button_event.sv
// ---------------------------------------------------------------------------
// button_event
//
// Purpose:
//   Sits behind the button debouncer and turns its clean, clk-synchronous
//   level into single-cycle press, release and long-press pulses, plus an
//   optional auto-repeat pulse while the button stays held. Press and repeat
//   events raise a held step request for the CPU single-step/run control,
//   which the consumer clears with step_ack_i. One instance per button.
//
//   Every output is registered; an event appears one clock after the
//   db_in_i sample that caused it.
//
// Configuration:
//   BUTTON_REPEAT_EN  when defined, the LONG state counts and emits a
//                     repeat pulse every REPEAT_TICKS cycles. When not
//                     defined, repeat_pulse_o is constant 0 and LONG just
//                     waits for the release.
//
// Parameters:
//   CW            width of the hold-time counter
//   LONG_TICKS    cycles held in DOWN before the long-press pulse (>= 2)
//   REPEAT_TICKS  cycles between auto-repeat pulses in LONG (>= 2)
//
// Ports:
//   clk_i           system clock
//   n_reset_i       asynchronous active-low reset
//   db_in_i         debounced button level, 1 = pressed
//   held_o          registered copy of db_in_i
//   press_o         one-cycle pulse on press
//   release_o       one-cycle pulse on release
//   long_press_o    one-cycle pulse when the hold reaches LONG_TICKS
//   repeat_pulse_o  one-cycle auto-repeat pulse
//   step_req_o      pending step request, held until acknowledged
//   step_ack_i      consumer accepts the pending step request
// ---------------------------------------------------------------------------
module button_event
  import button_event_pkg::*;
#(
  parameter int CW           = DEFAULT_CW,
  parameter int LONG_TICKS   = DEFAULT_LONG_TICKS,
  parameter int REPEAT_TICKS = DEFAULT_REPEAT_TICKS
) (
  input  logic clk_i,
  input  logic n_reset_i,
  input  logic db_in_i,
  output logic held_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o,
  output logic repeat_pulse_o,
  output logic step_req_o,
  input  logic step_ack_i
);

  // Thresholds must fit the counter and leave room for the settle cycle;
  // a bad instance is stopped at elaboration rather than misbehaving.
  if (LONG_TICKS < 2 || REPEAT_TICKS < 2 ||
      longint'(LONG_TICKS) >= (longint'(1) << CW) ||
      longint'(REPEAT_TICKS) >= (longint'(1) << CW)) begin : gBadParams
    $error("button_event: LONG_TICKS and REPEAT_TICKS must be >= 2 and < 2**CW");
  end

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
`ifdef BUTTON_REPEAT_EN
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);
`endif

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          fresh_q;
  logic          fresh_d;
  logic          held_q;
  btn_events_t   ev_q;
  btn_events_t   ev_d;
  logic          stepSet;

  // State register. Besides the state and the hold counter it keeps
  // fresh_q, which is high for exactly the first cycle after any state
  // change. The counter does not advance in that cycle, which is what puts
  // the long-press LONG_TICKS+1 cycles after the press pulse and the first
  // repeat REPEAT_TICKS+1 cycles after the long-press, while later repeats
  // (no state change) come every REPEAT_TICKS cycles.
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fresh_q <= fresh_d;
    end
  end

  // Next-state and counter logic. A low db_in_i is tested first in DOWN and
  // LONG so a release always beats a long-press or repeat that would fall
  // on the same cycle. The counter is cleared on every state change and
  // whenever it hits a threshold, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (db_in_i) begin
          state_d = DOWN;
        end
      end
      DOWN: begin
        if (!db_in_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (fresh_q) begin
          cnt_d = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LONG: begin
        if (!db_in_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
`ifdef BUTTON_REPEAT_EN
          if (fresh_q) begin
            cnt_d = '0;
          end else if (cnt_q == REPEAT_LAST) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`else
          cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    fresh_d = (state_d != state_q);
  end

  // Event decode. Each pulse is derived from the transition being taken,
  // so at most one can be high: press is IDLE->DOWN, release is any exit to
  // IDLE, long-press is DOWN->LONG, and repeat is a counter wrap while
  // staying in LONG.
  always_comb begin
    ev_d           = '0;
    ev_d.press     = (state_q == IDLE) && (state_d == DOWN);
    ev_d.rel       = ((state_q == DOWN) || (state_q == LONG)) && (state_d == IDLE);
    ev_d.longPress = (state_q == DOWN) && (state_d == LONG);
`ifdef BUTTON_REPEAT_EN
    ev_d.repeatPulse = (state_q == LONG) && (state_d == LONG) &&
                       !fresh_q && (cnt_q == REPEAT_LAST);
`endif
  end

  // Output register for the level copy and the event pulses. Reset clears
  // everything at once, so a reset during a hold never produces a release.
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      held_q <= 1'b0;
      ev_q   <= '0;
    end else begin
      held_q <= db_in_i;
      ev_q   <= ev_d;
    end
  end

  // The request is raised from the same decode that launches the press or
  // repeat pulse, so step_req_o rises in the same cycle as that pulse.
  assign stepSet = ev_d.press | ev_d.repeatPulse;

  button_event_step_handshake uStepHandshake (
    .clk_i     (clk_i),
    .n_reset_i (n_reset_i),
    .set_i     (stepSet),
    .ack_i     (step_ack_i),
    .req_o     (step_req_o)
  );

  assign held_o         = held_q;
  assign press_o        = ev_q.press;
  assign release_o      = ev_q.rel;
  assign long_press_o   = ev_q.longPress;
  assign repeat_pulse_o = ev_q.repeatPulse;

endmodule

// File: tb/tb_button_event.sv
// ---------------------------------------------------------------------------
// tb_button_event
//
// Directed bench for button_event with LONG_TICKS=8 and REPEAT_TICKS=4.
// Each step drives db_in/step_ack on the falling edge, works out the
// expected registered outputs from the event-level description (press on a
// rising sample, long-press on the (LONG_TICKS+1)th sample after the press
// sample, repeats REPEAT_TICKS+1 and then every REPEAT_TICKS samples later,
// release on a falling sample), pushes that into a queue, and compares the
// DUT one time unit after the following rising edge. Expectations for the
// repeat pulse follow whether BUTTON_REPEAT_EN is defined for this build.
// ---------------------------------------------------------------------------
module tb_button_event;

  localparam int CW           = 16;
  localparam int LONG_TICKS   = 8;
  localparam int REPEAT_TICKS = 4;
`ifdef BUTTON_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif
  localparam int FIRST_REPEAT = LONG_TICKS + REPEAT_TICKS + 2;

  typedef struct packed {
    logic held;
    logic press;
    logic rel;
    logic longPress;
    logic repeatPulse;
    logic stepReq;
  } outs_t;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic dbIn = 1'b0;
  logic stepAck = 1'b0;
  logic heldOut;
  logic pressOut;
  logic relOut;
  logic longOut;
  logic repeatOut;
  logic stepReqOut;

  outs_t expQ[$];
  int checks = 0;
  int errors = 0;
  int stepNo = 0;

  logic mPrev = 1'b0;
  logic mReq = 1'b0;
  int   mIdx = 0;

  button_event #(
    .CW           (CW),
    .LONG_TICKS   (LONG_TICKS),
    .REPEAT_TICKS (REPEAT_TICKS)
  ) dut (
    .clk_i          (clk),
    .n_reset_i      (nReset),
    .db_in_i        (dbIn),
    .held_o         (heldOut),
    .press_o        (pressOut),
    .release_o      (relOut),
    .long_press_o   (longOut),
    .repeat_pulse_o (repeatOut),
    .step_req_o     (stepReqOut),
    .step_ack_i     (stepAck)
  );

  always #5 clk = ~clk;

  // Reference for one sampled cycle, written in terms of how long the
  // button has been held rather than in terms of the DUT's FSM.
  task automatic modelStep(input logic db, input logic ack, output outs_t e);
    e = '0;
    e.held = db;
    if (db) begin
      if (!mPrev) begin
        mIdx = 0;
        e.press = 1'b1;
      end else begin
        mIdx++;
        if (mIdx == LONG_TICKS + 1) begin
          e.longPress = 1'b1;
        end else if (REPEAT_ON != 1'b0 && mIdx >= FIRST_REPEAT &&
                     ((mIdx - FIRST_REPEAT) % REPEAT_TICKS) == 0) begin
          e.repeatPulse = 1'b1;
        end
      end
    end else if (mPrev) begin
      e.rel = 1'b1;
    end
    mReq = e.press | e.repeatPulse | (mReq & ~ack);
    e.stepReq = mReq;
    mPrev = db;
  endtask

  task automatic modelReset();
    mPrev = 1'b0;
    mReq  = 1'b0;
    mIdx  = 0;
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic compareNow(input string tag);
    outs_t e;
    string t;
    checks++;
    assert (expQ.size() > 0) else begin
      errors++;
      $error("[TB] FAIL %s scoreboard observed=empty expected=entry", tag);
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      t = $sformatf("%s#%0d", tag, stepNo);
      checkBit({t, ".held"},        heldOut,    e.held);
      checkBit({t, ".press"},       pressOut,   e.press);
      checkBit({t, ".release"},     relOut,     e.rel);
      checkBit({t, ".long_press"},  longOut,    e.longPress);
      checkBit({t, ".repeat"},      repeatOut,  e.repeatPulse);
      checkBit({t, ".step_req"},    stepReqOut, e.stepReq);
    end
  endtask

  task automatic applyStimulus(input logic db, input logic ack);
    outs_t e;
    @(negedge clk);
    dbIn    = db;
    stepAck = ack;
    modelStep(db, ack, e);
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    @(posedge clk);
    #1;
    stepNo++;
    compareNow(tag);
  endtask

  task automatic stepCycle(input logic db, input logic ack, input string tag);
    applyStimulus(db, ack);
    checkOutput(tag);
  endtask

  initial begin
    $display("[TB] button_event bench, repeat feature %0s", REPEAT_ON ? "on" : "off");

    // Power-up reset: everything must read zero.
    #12;
    modelReset();
    expQ.push_back('0);
    compareNow("reset");
    @(posedge clk);
    #3;
    nReset = 1'b1;

    repeat (2) stepCycle(1'b0, 1'b0, "idle");

    // Ten-cycle hold: press, long-press on the last held sample, release.
    repeat (10) stepCycle(1'b1, 1'b0, "hold10");
    repeat (3) stepCycle(1'b0, 1'b0, "fall10");
    stepCycle(1'b0, 1'b1, "ack10");
    stepCycle(1'b0, 1'b0, "idle");

    // Thirty-cycle hold: repeats only when the feature is built in.
    repeat (30) stepCycle(1'b1, 1'b0, "hold30");
    repeat (3) stepCycle(1'b0, 1'b0, "fall30");
    stepCycle(1'b0, 1'b1, "ack30");
    stepCycle(1'b0, 1'b0, "idle");

    // Fall exactly on the long-press threshold: release only.
    repeat (9) stepCycle(1'b1, 1'b0, "hold9");
    repeat (3) stepCycle(1'b0, 1'b0, "fall9");
    stepCycle(1'b0, 1'b1, "ack9");
    stepCycle(1'b0, 1'b0, "idle");

    // Acknowledge sampled on the same edge that launches the first repeat
    // keeps the request up; the next acknowledge then clears it.
    repeat (14) stepCycle(1'b1, 1'b0, "holdAck");
    stepCycle(1'b1, 1'b1, "ackOnRepeat");
    stepCycle(1'b1, 1'b1, "ackAfter");
    repeat (2) stepCycle(1'b1, 1'b0, "holdAck");
    repeat (2) stepCycle(1'b0, 1'b0, "fallAck");
    stepCycle(1'b0, 1'b1, "ackClear");
    stepCycle(1'b0, 1'b0, "idle");

    // Pending request, new press with acknowledge on the same edge.
    stepCycle(1'b1, 1'b0, "tap");
    stepCycle(1'b0, 1'b0, "tapFall");
    stepCycle(1'b1, 1'b1, "pressAck");
    stepCycle(1'b1, 1'b0, "pressAckHold");
    stepCycle(1'b0, 1'b1, "pressAckClr");
    stepCycle(1'b0, 1'b0, "idle");

    // Reset in the middle of a long hold with a request pending.
    repeat (12) stepCycle(1'b1, 1'b0, "holdRst");
    #2;
    nReset = 1'b0;
    #1;
    modelReset();
    expQ.push_back('0);
    compareNow("asyncReset");
    repeat (2) begin
      expQ.push_back('0);
      checkOutput("inReset");
    end
    @(posedge clk);
    #3;
    nReset = 1'b1;
    stepCycle(1'b1, 1'b0, "pressAfterRst");
    repeat (3) stepCycle(1'b1, 1'b0, "holdAfterRst");
    repeat (2) stepCycle(1'b0, 1'b0, "fallAfterRst");

    // Acknowledge held with no events: nothing may fire.
    repeat (20) stepCycle(1'b0, 1'b1, "ackIdle");
    stepCycle(1'b0, 1'b0, "idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Backstop so the run always ends even if a wait above never returns.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
